// File: rtl/fifo_wr_packer_if.sv
// fifo_wr_packer_if
//   Bundles the upstream word handshake and the async-FIFO write port used by
//   fifo_wr_packer.
//   Signals:
//     in_data           upstream word (IN_WIDTH)
//     in_valid          in_data is valid
//     in_ready          packer can take a word this cycle
//     fifo_full         full flag from the async FIFO
//     fifo_write_data   chunk presented to the FIFO (OUT_WIDTH)
//     fifo_write_enable FIFO write strobe
//   Modports:
//     master  environment side (word source + FIFO)
//     slave   packer side
interface fifo_wr_packer_if #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 6
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 fifo_full;
    logic [OUT_WIDTH-1:0] fifo_write_data;
    logic                 fifo_write_enable;

    modport master (
        output in_data,
        output in_valid,
        output fifo_full,
        input  in_ready,
        input  fifo_write_data,
        input  fifo_write_enable
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  fifo_full,
        output in_ready,
        output fifo_write_data,
        output fifo_write_enable
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
//   Splits each IN_WIDTH upstream word into K = IN_WIDTH/OUT_WIDTH chunks and
//   writes them LSB-first into an async FIFO, one chunk per cycle while the
//   FIFO is not full. A new word can be taken on the same edge the last chunk
//   of the previous one is written, giving one word per K cycles sustained.
//   Ports:
//     write_clk    clock (FIFO write domain)
//     reset        synchronous, active-high
//     bus          fifo_wr_packer_if.slave: in_data/in_valid/in_ready and
//                  fifo_full/fifo_write_data/fifo_write_enable
//     word_done    pulse in the cycle the final chunk of a word is written
//     busy         a word is held
//     stall_count  16-bit saturating count of SEND cycles blocked by
//                  fifo_full; present only when FWP_STALL_CNT_EN is defined
//   Optional feature macro: FWP_STALL_CNT_EN
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 6
) (
    input  logic                 write_clk,
    input  logic                 reset,
    fifo_wr_packer_if.slave      bus,
    output logic                 word_done,
    output logic                 busy
`ifdef FWP_STALL_CNT_EN
    ,
    output logic [15:0]          stall_count
`endif
);
    localparam int K     = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    if (IN_WIDTH != K * OUT_WIDTH || K < 2) begin : g_bad_cfg
        $error("fifo_wr_packer: IN_WIDTH must be an integer multiple K>=2 of OUT_WIDTH");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 idx;
    logic [K-1:0][OUT_WIDTH-1:0]      hold;
    logic                             last_chunk;
    logic                             accept;

    assign last_chunk            = (idx == IDX_W'(K - 1));
    assign bus.fifo_write_enable = (state == SEND) && !bus.fifo_full;
    // Ready on the last chunk lets the next word load with no idle cycle.
    assign bus.in_ready          = (state == IDLE) ||
                                   ((state == SEND) && last_chunk && !bus.fifo_full);
    assign bus.fifo_write_data   = hold[idx];
    assign accept                = bus.in_valid && bus.in_ready;
    assign word_done             = bus.fifo_write_enable && last_chunk;
    assign busy                  = (state == SEND);

    always_ff @(posedge write_clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold  <= bus.in_data;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    // fifo_full freezes everything so no chunk is lost or repeated.
                    if (!bus.fifo_full) begin
                        if (last_chunk) begin
                            idx <= '0;
                            if (accept) begin
                                hold <= bus.in_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

`ifdef FWP_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge write_clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if ((state == SEND) && bus.fifo_full) begin
            stall_count <= sat_inc16(stall_count);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer
//   Directed scenarios followed by a randomized phase, all checked against a
//   reference model holding the queue of chunks still owed to the FIFO.
module tb_fifo_wr_packer;
    localparam int IW = 24;
    localparam int OW = 6;
    localparam int K  = IW / OW;

    logic write_clk = 1'b0;
    logic reset     = 1'b1;
    logic word_done;
    logic busy;
`ifdef FWP_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    fifo_wr_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus();

    fifo_wr_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .write_clk (write_clk),
        .reset     (reset),
        .bus       (bus),
        .word_done (word_done),
        .busy      (busy)
`ifdef FWP_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    always #5 write_clk = ~write_clk;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];   // chunks of the held word not yet written
    logic [OW-1:0] wlog[$];    // chunks actually written by the DUT
    bit            hold_zero = 1'b1;
    int            stall_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wl(input int i);
        if (i < wlog.size()) return 32'(wlog[i]);
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model at the posedge.
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic f, input logic r);
        bit held, we_e, rdy_e, done_e;
        @(negedge write_clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.fifo_full = f;
        reset         = r;
        #1;
        held   = (exp_q.size() != 0);
        we_e   = held && !f;
        rdy_e  = !held || (exp_q.size() == 1 && !f);
        done_e = we_e && (exp_q.size() == 1);
        chk("write_enable", 32'(bus.fifo_write_enable), 32'(we_e));
        chk("in_ready",     32'(bus.in_ready),          32'(rdy_e));
        chk("busy",         32'(busy),                  32'(held));
        chk("word_done",    32'(word_done),             32'(done_e));
        if (held)           chk("write_data", 32'(bus.fifo_write_data), 32'(exp_q[0]));
        else if (hold_zero) chk("data_zero",  32'(bus.fifo_write_data), 32'd0);
`ifdef FWP_STALL_CNT_EN
        chk("stall_count", 32'(stall_count), 32'(stall_model));
`endif
        if (bus.fifo_write_enable) wlog.push_back(bus.fifo_write_data);
        @(posedge write_clk);
        if (r) begin
            exp_q.delete();
            hold_zero   = 1'b1;
            stall_model = 0;
        end else begin
            if (held && f && stall_model < 65535) stall_model++;
            if (we_e) void'(exp_q.pop_front());
            if (v && rdy_e) begin
                for (int i = 0; i < K; i++) exp_q.push_back(OW'(d >> (OW * i)));
                hold_zero = 1'b0;
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 24'h555555;
        bus.fifo_full = 1'b0;

        // Reset with in_valid high: nothing may be accepted.
        cycle(1'b1, 24'h555555, 1'b0, 1'b1);
        cycle(1'b1, 24'h555555, 1'b0, 1'b1);
        cycle(1'b0, 24'h0, 1'b0, 1'b0);

        // Single word.
        wlog.delete();
        cycle(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("single_len", wlog.size(), 4);
        chk("single_w0", wl(0), 32'h2F);
        chk("single_w1", wl(1), 32'h37);
        chk("single_w2", wl(2), 32'h3C);
        chk("single_w3", wl(3), 32'h2A);

        // Back-to-back words with in_valid held high.
        wlog.delete();
        cycle(1'b1, 24'h000001, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("b2b_len", wlog.size(), 8);
        chk("b2b_w0", wl(0), 32'h01);
        chk("b2b_w1", wl(1), 32'h00);
        chk("b2b_w2", wl(2), 32'h00);
        chk("b2b_w3", wl(3), 32'h00);
        chk("b2b_w4", wl(4), 32'h3F);
        chk("b2b_w5", wl(5), 32'h3F);
        chk("b2b_w6", wl(6), 32'h3F);
        chk("b2b_w7", wl(7), 32'h3F);
        cycle(1'b0, 24'h0, 1'b0, 1'b0);

        // Backpressure on the second chunk.
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        wlog.delete();
        cycle(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0);
        repeat (3) begin
            cycle(1'b0, 24'h0, 1'b1, 1'b0);
            chk("stall_data", 32'(bus.fifo_write_data), 32'h37);
        end
        repeat (4) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("bp_len", wlog.size(), 4);
        chk("bp_w0", wl(0), 32'h2F);
        chk("bp_w1", wl(1), 32'h37);
        chk("bp_w2", wl(2), 32'h3C);
        chk("bp_w3", wl(3), 32'h2A);
`ifdef FWP_STALL_CNT_EN
        chk("bp_stall_count", 32'(stall_count), 32'd3);
`endif

        // Full on the last chunk while a new word waits.
        wlog.delete();
        cycle(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 24'h123456, 1'b1, 1'b0);
        cycle(1'b1, 24'h123456, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("fl_len", wlog.size(), 8);
        chk("fl_w3", wl(3), 32'h2A);
        chk("fl_w4", wl(4), 32'h16);
        chk("fl_w5", wl(5), 32'h11);
        chk("fl_w6", wl(6), 32'h23);
        chk("fl_w7", wl(7), 32'h04);

        // Reset after two chunks written.
        cycle(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        wlog.delete();
        cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        cycle(1'b1, 24'h123456, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 24'h0, 1'b0, 1'b0);
        chk("rst_len", wlog.size(), 4);
        chk("rst_w0", wl(0), 32'h16);
        chk("rst_w3", wl(3), 32'h04);

        // Randomized traffic with occasional full and reset.
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)), 24'($urandom),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 99) < 2));
        end

`ifdef FWP_STALL_CNT_EN
        // Long stall: counter saturates instead of wrapping.
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        cycle(1'b1, 24'h0F0F0F, 1'b0, 1'b0);
        repeat (70000) cycle(1'b0, 24'h0, 1'b1, 1'b0);
        chk("sat_stall_count", 32'(stall_count), 32'hFFFF);
        repeat (5) cycle(1'b0, 24'h0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
